// File: rtl/mem_arbiter_if.sv
// Processor-side request/response and RAM-side strobe bundle
// shared by the memory arbiter and its environment.
interface mem_arbiter_if;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_rdy;

  modport slave (
    input  halt, iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ram_rdy,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output halt, iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ram_rdy,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data-first priority with a bounded
// data streak so pending fetches are not starved.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } state_t;

  state_t      state;
  logic        owner_d;
  logic [3:0]  dstreak;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        ren_q;
  logic        wen_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;

  logic dreq;
  logic d_first;
  logic resp_i;
  logic resp_d;

  assign dreq    = bus.dREN | bus.dWEN;
  assign d_first = dstreak < 4'(MAX_DSTREAK)
                 || !bus.iREN || bus.halt;
  assign resp_i  = (state == RESP) && !owner_d;
  assign resp_d  = (state == RESP) && owner_d;

  assign bus.iwait    = bus.iREN & ~resp_i;
  assign bus.dwait    = dreq & ~resp_d;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      dstreak <= '0;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dreq && d_first) begin
            state   <= GNT_D;
            owner_d <= 1'b1;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            // a simultaneous read+write request is served as a write
            ren_q   <= ~bus.dWEN;
            wen_q   <= bus.dWEN;
            if (!bus.iREN)
              dstreak <= '0;
            else if (dstreak != 4'hF)
              dstreak <= dstreak + 4'd1;
          end else if (bus.iREN && !bus.halt) begin
            state   <= GNT_I;
            owner_d <= 1'b0;
            addr_q  <= bus.iaddr;
            store_q <= '0;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            dstreak <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (bus.ram_rdy) begin
            state <= RESP;
            ren_q <= 1'b0;
            wen_q <= 1'b0;
            if (!owner_d)
              iload_q <= bus.ramload;
            else if (!wen_q)
              dload_q <= bus.ramload;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: grant order,
// strobe stability, completion data and wait handshakes.
module tb_mem_arbiter;
  logic CLK;
  logic RST;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
  } txn_t;

  txn_t q[$];
  int compared;
  int mismatched;
  int wait_states;

  localparam logic [31:0] RAM_KEY = 32'h2002_0041;

  // RAM read data is a fixed function of the address
  assign bus.ramload = bus.ramaddr ^ RAM_KEY;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic d, input logic we,
                               input logic [31:0] a,
                               input logic [31:0] s);
    txn_t t;
    t.d     = d;
    t.we    = we;
    t.addr  = a;
    t.store = s;
    t.rdata = we ? 32'h0 : (a ^ RAM_KEY);
    q.push_back(t);
  endfunction

  // RAM model: wait_states low cycles of ram_rdy per grant
  initial begin : ram_model
    int cnt;
    bit in_grant;
    cnt = 0;
    in_grant = 0;
    bus.ram_rdy = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.ramREN | bus.ramWEN) begin
        if (!in_grant) begin
          cnt = wait_states;
          in_grant = 1;
        end
        bus.ram_rdy = (cnt == 0);
        if (cnt > 0) cnt--;
      end else begin
        in_grant = 0;
        bus.ram_rdy = 1'b1;
      end
    end
  end

  // Monitor: pops an expected grant whenever a new RAM access starts
  initial begin : monitor
    txn_t cur;
    bit active;
    bit resp;
    active = 0;
    resp = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (RST) begin
        active = 0;
        resp = 0;
      end else begin
        if (resp) begin
          chk("resp_ren", {31'b0, bus.ramREN}, 32'd0);
          chk("resp_wen", {31'b0, bus.ramWEN}, 32'd0);
          if (cur.d) begin
            if (!cur.we) chk("dload", bus.dload, cur.rdata);
            if (bus.dREN | bus.dWEN)
              chk("dwait_resp", {31'b0, bus.dwait}, 32'd0);
          end else begin
            chk("iload", bus.iload, cur.rdata);
            if (bus.iREN)
              chk("iwait_resp", {31'b0, bus.iwait}, 32'd0);
          end
          resp = 0;
        end
        if (active && !(bus.ramREN | bus.ramWEN)) active = 0;
        if ((bus.ramREN | bus.ramWEN) && !active) begin
          compared++;
          if (q.size() == 0) begin
            mismatched++;
            $display("FAIL grant: unexpected access addr %h",
                     bus.ramaddr);
            cur = '0;
          end else begin
            cur = q.pop_front();
          end
          active = 1;
        end
        if (active) begin
          chk("ramaddr", bus.ramaddr, cur.addr);
          chk("ramWEN", {31'b0, bus.ramWEN}, {31'b0, cur.we});
          chk("ramREN", {31'b0, bus.ramREN}, {31'b0, ~cur.we});
          if (cur.we) chk("ramstore", bus.ramstore, cur.store);
          if (bus.ram_rdy) begin
            resp = 1;
            active = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic wait_port(input bit d, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((d ? bus.dwait : bus.iwait) && n < 40);
    if (d ? bus.dwait : bus.iwait) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: port %0d wait still %0d after %0d",
               d, 1, n);
    end
  endtask

  initial begin : stim
    int n;
    int ev;
    compared = 0;
    mismatched = 0;
    wait_states = 0;
    RST = 1'b1;
    bus.halt = 0;
    bus.iREN = 0;
    bus.iaddr = '0;
    bus.dREN = 0;
    bus.dWEN = 0;
    bus.daddr = '0;
    bus.dstore = '0;
    tick();
    tick();
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    chk("rst_addr", bus.ramaddr, 32'd0);
    chk("rst_store", bus.ramstore, 32'd0);
    chk("rst_iwait", {31'b0, bus.iwait}, 32'd0);
    bus.iREN = 1;
    #1;
    chk("rst_iwait_req", {31'b0, bus.iwait}, 32'd1);
    bus.iREN = 0;
    RST = 1'b0;
    tick();

    // fetch alone
    bus.iREN = 1;
    bus.iaddr = 32'h40;
    push(0, 0, 32'h40, 0);
    wait_port(0, n);
    chk("fetch_lat", n, 32'd2);
    chk("fetch_word", bus.iload, 32'h2002_0001);
    tick();
    chk("fetch_iwait_again", {31'b0, bus.iwait}, 32'd1);
    bus.iREN = 0;
    tick();

    // data priority over a simultaneous fetch
    bus.iREN = 1;
    bus.iaddr = 32'h44;
    bus.dWEN = 1;
    bus.daddr = 32'h100;
    bus.dstore = 32'hDEAD_BEEF;
    push(1, 1, 32'h100, 32'hDEAD_BEEF);
    push(0, 0, 32'h44, 0);
    wait_port(1, n);
    chk("write_lat", n, 32'd2);
    bus.dWEN = 0;
    bus.dstore = 0;
    wait_port(0, n);
    chk("fetch_after_write", n, 32'd3);
    bus.iREN = 0;
    tick();

    // starvation guard: D,D,D,D,I,D
    bus.iREN = 1;
    bus.iaddr = 32'h80;
    bus.dREN = 1;
    bus.daddr = 32'h300;
    for (int k = 0; k < 4; k++) push(1, 0, 32'h300, 0);
    push(0, 0, 32'h80, 0);
    push(1, 0, 32'h300, 0);
    ev = 0;
    for (int k = 0; k < 60 && ev < 5; k++) begin
      tick();
      if (!bus.dwait) ev++;
    end
    chk("streak_events", ev, 32'd5);
    bus.iREN = 0;
    bus.dREN = 0;
    tick();

    // RAM wait states with daddr toggling during the grant
    wait_states = 5;
    bus.dREN = 1;
    bus.daddr = 32'h200;
    push(1, 0, 32'h200, 0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!bus.dwait) break;
      bus.daddr = bus.daddr ^ 32'h0000_0FF0;
    end
    chk("wait_lat", n, 32'd7);
    chk("wait_dload", bus.dload, 32'h2002_0241);
    bus.dREN = 0;
    bus.daddr = 32'h200;
    wait_states = 0;
    tick();

    // halt: only data served, fetch blocked
    bus.halt = 1;
    bus.iREN = 1;
    bus.iaddr = 32'h90;
    bus.dREN = 1;
    bus.daddr = 32'h400;
    push(1, 0, 32'h400, 0);
    push(1, 0, 32'h400, 0);
    ev = 0;
    for (int k = 0; k < 40 && ev < 2; k++) begin
      tick();
      if (!bus.dwait) ev++;
    end
    chk("halt_d_events", ev, 32'd2);
    bus.dREN = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_iwait", {31'b0, bus.iwait}, 32'd1);
      chk("halt_no_ren", {31'b0, bus.ramREN}, 32'd0);
    end
    bus.iREN = 0;
    bus.halt = 0;
    tick();

    // halt raised during GNT_I: that fetch still completes
    bus.iREN = 1;
    bus.iaddr = 32'hA0;
    push(0, 0, 32'hA0, 0);
    tick();
    chk("halt_gnt_ren", {31'b0, bus.ramREN}, 32'd1);
    bus.halt = 1;
    wait_port(0, n);
    chk("halt_gnt_lat", n, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_after_iwait", {31'b0, bus.iwait}, 32'd1);
    end
    bus.iREN = 0;
    bus.halt = 0;
    tick();

    // reset asserted mid-grant abandons the write
    wait_states = 3;
    bus.dWEN = 1;
    bus.daddr = 32'h500;
    bus.dstore = 32'h1234_5678;
    push(1, 1, 32'h500, 32'h1234_5678);
    push(1, 1, 32'h500, 32'h1234_5678);
    tick();
    chk("pre_rst_wen", {31'b0, bus.ramWEN}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid_wen", {31'b0, bus.ramWEN}, 32'd0);
    chk("rst_mid_dload", bus.dload, 32'd0);
    chk("rst_mid_dwait", {31'b0, bus.dwait}, 32'd1);
    tick();
    RST = 1'b0;
    wait_port(1, n);
    chk("regrant_lat", n, 32'd5);
    chk("regrant_dload", bus.dload, 32'd0);
    bus.dWEN = 0;
    bus.dstore = 0;
    wait_states = 0;
    tick();
    tick();
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
